// File: rtl/aes_cipher_pkg.sv
// Shared AES types, build-size constants and round helper functions.
package aes_cipher_pkg;

`ifdef AES256
    localparam int Nr       = 14;
    localparam int KEY_SIZE = 256;
    localparam int Nk       = 8;
`elsif AES192
    localparam int Nr       = 12;
    localparam int KEY_SIZE = 192;
    localparam int Nk       = 6;
`else
    localparam int Nr       = 10;
    localparam int KEY_SIZE = 128;
    localparam int Nk       = 4;
`endif

    typedef logic [7:0] byte_t;
    // Element [15] is byte 0 (bits 127:120); byte n sits at row n%4, column n/4.
    typedef byte_t [15:0] aes_state_t;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply; only used to build the S-box inverse.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(15 - (4 * c + r))] = s[4'(15 - (4 * ((c + r) % 4) + r))];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        byte_t a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(15 - 4 * c)];
            a1 = s[4'(14 - 4 * c)];
            a2 = s[4'(13 - 4 * c)];
            a3 = s[4'(12 - 4 * c)];
            o[4'(15 - 4 * c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[4'(14 - 4 * c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[4'(13 - 4 * c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[4'(12 - 4 * c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_cipher_sbox.sv
// AES forward S-box: multiplicative inverse (x^254) followed by the affine map.
module aes_cipher_sbox
    import aes_cipher_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    byte_t x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

    // Square-and-multiply chain to x^254; zero maps to zero as required.
    always_comb begin
        x2   = gf_mul(a_i, a_i);
        x3   = gf_mul(x2, a_i);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, a_i);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, a_i);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, a_i);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, a_i);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, a_i);
        inv  = gf_mul(x127, x127);
        y_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES encryption core: one round per clock, Nr+1 cycles per block.
module aes_cipher
    import aes_cipher_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [127:0]          block_i,
    input  logic [Nr:0][127:0]    round_key_i,
    output logic                  valid_o,
    output logic [127:0]          block_o
);

    localparam int RND_W = $clog2(Nr + 1);

    typedef enum logic {IDLE, RUN} fsm_e;

    fsm_e             fsm_q, fsm_d;
    aes_state_t       state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             valid_q, valid_d;
    logic [127:0]     blk_q, blk_d;

    aes_state_t       sub, sr, rnd_out;
    logic             last_rnd;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_cipher_sbox u_sbox (.a_i(state_q[i]), .y_o(sub[i]));
    end

    // Round datapath; the final round skips MixColumns.
    always_comb begin
        last_rnd = (rnd_q == RND_W'(Nr));
        sr       = shift_rows(sub);
        rnd_out  = (last_rnd ? sr : mix_columns(sr)) ^ round_key_i[rnd_q];
    end

    // Next-state logic: accept in IDLE, iterate rounds in RUN.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        valid_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = block_i ^ round_key_i[0];
                    rnd_d   = RND_W'(1);
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = rnd_out;
                if (last_rnd) begin
                    blk_d   = rnd_out;
                    valid_d = 1'b1;
                    fsm_d   = IDLE;
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // All state and outputs are registered; reset discards any in-flight block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            blk_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            blk_q   <= blk_d;
        end
    end

    assign ready_o = (fsm_q == IDLE);
    assign valid_o = valid_q;
    assign block_o = blk_q;

endmodule

// File: tb/tb_aes_cipher.sv
// Directed bench for aes_cipher using FIPS-197 vectors.
module tb_aes_cipher;
    import aes_cipher_pkg::*;

    typedef logic [Nr:0][127:0] rk_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] block_i;
    rk_t          round_key_i;
    logic         valid_o;
    logic [127:0] block_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_cipher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .block_i     (block_i),
        .round_key_i (round_key_i),
        .valid_o     (valid_o),
        .block_o     (block_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_xtime(input logic [7:0] x);
        return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= t;
            t = m_xtime(t);
        end
        return p;
    endfunction

    // Reference S-box via brute-force inverse search.
    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] r;
        for (int y = 1; y < 256; y++)
            if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        r = 8'h63;
        for (int i = 0; i < 8; i++)
            r[i] = r[i] ^ inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                        ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
        return r;
    endfunction

    function automatic logic [31:0] m_subword(input logic [31:0] w);
        return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
    endfunction

    // Key schedule; key is left-aligned in 256 bits.
    function automatic rk_t expand(input logic [255:0] key);
        logic [31:0] w [0:4*(Nr+1)-1];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        rk_t         rk;
        for (int i = 0; i < Nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = Nk; i < 4 * (Nr + 1); i++) begin
            t = w[i-1];
            if (i % Nk == 0) begin
                t = m_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = m_xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
                t = m_subword(t);
            end
            w[i] = w[i-Nk] ^ t;
        end
        for (int r = 0; r <= Nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait for valid_o; n counts edges since the call.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!valid_o && n < 40);
    endtask

    task automatic run(input string tag, input logic [127:0] pt, input rk_t rk,
                       input logic [127:0] exp);
        int n;
        @(negedge clk);
        valid_i = 1'b1; block_i = pt; round_key_i = rk;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check({tag, "_busy"}, 128'(ready_o), 128'(0));
        wait_done(n);
        check({tag, "_latency"}, 128'(n), 128'(Nr));
        check({tag, "_ct"}, block_o, exp);
        check({tag, "_ready"}, 128'(ready_o), 128'(1));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 128'(valid_o), 128'(0));
    endtask

    initial begin
        int   n, n2, gap, extra;
        rk_t  rk_b, rk_c;
        logic [127:0] ct_c;

        rk_b = expand(KEY_B);
        rk_c = expand(KEY_C);
        ct_c = (Nr == 10) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
               (Nr == 12) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                            128'h8ea2b7ca516745bfeafc49904b496089;

        rst_n = 1'b0; valid_i = 1'b0; block_i = '0; round_key_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_ready", 128'(ready_o), 128'(1));
        check("rst_valid", 128'(valid_o), 128'(0));
        check("rst_block", block_o, 128'(0));

        run("appB", PT_B, rk_b, CT_B);
        run("c_vec", PT_C, rk_c, ct_c);

        // Back-to-back with valid_i held high.
        @(negedge clk);
        valid_i = 1'b1; block_i = PT_B; round_key_i = rk_b;
        @(posedge clk); #1;
        wait_done(n);
        check("b2b_lat1", 128'(n), 128'(Nr));
        check("b2b_ct1", block_o, CT_B);
        block_i = PT_C; round_key_i = rk_c;
        @(posedge clk); #1;
        gap = n + 1;
        check("b2b_accept2", 128'(ready_o), 128'(0));
        check("b2b_gap", 128'(gap), 128'(11));
        valid_i = 1'b0;
        wait_done(n);
        check("b2b_lat2", 128'(n), 128'(Nr));
        check("b2b_ct2", block_o, ct_c);

        // Busy input at round 5 must be ignored.
        @(negedge clk);
        valid_i = 1'b1; block_i = PT_B; round_key_i = rk_b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        valid_i = 1'b1; block_i = '0;
        check("busy_ready", 128'(ready_o), 128'(0));
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_done(n2);
        check("busy_lat", 128'(5 + n2), 128'(Nr));
        check("busy_ct", block_o, CT_B);
        extra = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (valid_o) extra++;
        end
        check("busy_extra", 128'(extra), 128'(0));

        // Reset in round 4.
        @(negedge clk);
        valid_i = 1'b1; block_i = PT_C; round_key_i = rk_c;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_block", block_o, 128'(0));
        check("mid_rst_valid", 128'(valid_o), 128'(0));
        check("mid_rst_ready", 128'(ready_o), 128'(1));
        @(negedge clk); rst_n = 1'b1;
        extra = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (valid_o) extra++;
        end
        check("mid_rst_novalid", 128'(extra), 128'(0));
        run("post_rst", PT_B, rk_b, CT_B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
